// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg -- types shared by the fetch path.
//   word_t         : 32-bit machine word
//   IIDX_W/ITAG_W  : index/tag widths of the default 16-frame instruction cache
//   icachef_t      : fetch address viewed as {tag, idx, bytoff}
//   icache_frame_t : one cache frame {valid, tag, data}
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   localparam int IIDX_W = 4;
   localparam int ITAG_W = 30 - IIDX_W;

   typedef struct packed {
      logic [ITAG_W-1:0] tag;
      logic [IIDX_W-1:0] idx;
      logic [1:0]        bytoff;
   } icachef_t;

   typedef struct packed {
      logic              valid;
      logic [ITAG_W-1:0] tag;
      word_t             data;
   } icache_frame_t;

endpackage

// File: rtl/icache.sv
// icache -- direct-mapped, one-word-per-frame instruction cache.
//   CLK, RST          : clock; synchronous active-high reset
//   imemREN/imemaddr  : datapath fetch request and address (bits [1:0] ignored)
//   ihit/imemload     : combinational hit and instruction word (0 on no hit)
//   iREN/iaddr        : fill request and word-aligned fill address to memory
//   iwait/iload       : memory busy flag and fill data (valid when iREN & !iwait)
// Hits complete in the same cycle. A miss latches the word address and holds
// a fill request until memory answers; the frame is then written and the
// cache returns to IDLE, where the re-lookup hits.
module icache
   import cpu_types_pkg::*;
#(
   parameter int SETS  = 16,
   parameter int IDX_W = 4
) (
   input  logic  CLK,
   input  logic  RST,
   input  logic  imemREN,
   input  word_t imemaddr,
   output logic  ihit,
   output word_t imemload,
   output logic  iREN,
   output word_t iaddr,
   input  logic  iwait,
   input  word_t iload
);

   localparam int TAG_W = 30 - IDX_W;

   typedef enum logic {IDLE, FILL} state_t;

   state_t state, next_state;

   // Frame storage: valid bits are reset, tag/data are not.
   logic [SETS-1:0] valid;
   logic [TAG_W-1:0] tags [SETS];
   word_t            data [SETS];

   // Word address of the outstanding miss; {tag, idx}.
   logic [29:0] miss_word;

   logic [TAG_W-1:0] req_tag;
   logic [IDX_W-1:0] req_idx;
   logic [TAG_W-1:0] fill_tag;
   logic [IDX_W-1:0] fill_idx;
   logic             lookup_hit;
   logic             fill_we;
   logic             miss_take;
   logic             unused_bytoff;

   assign req_tag       = imemaddr[31:IDX_W+2];
   assign req_idx       = imemaddr[IDX_W+1:2];
   assign fill_tag      = miss_word[29:IDX_W];
   assign fill_idx      = miss_word[IDX_W-1:0];
   assign unused_bytoff = ^imemaddr[1:0];

   assign lookup_hit = valid[req_idx] && (tags[req_idx] == req_tag);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // NOTE: every output and strobe gets a default before the case so no
   // path through this block leaves a value unassigned (no latches).
   always_comb begin
      next_state = state;
      ihit       = 1'b0;
      imemload   = '0;
      iREN       = 1'b0;
      iaddr      = '0;
      fill_we    = 1'b0;
      miss_take  = 1'b0;
      unique case (state)
         IDLE: begin
            if (imemREN) begin
               if (lookup_hit) begin
                  ihit     = 1'b1;
                  imemload = data[req_idx];
               end else begin
                  miss_take  = 1'b1;
                  next_state = FILL;
               end
            end
         end
         FILL: begin
            // The latched address is serviced regardless of what the
            // datapath does meanwhile.
            iREN  = 1'b1;
            iaddr = {miss_word, 2'b00};
            if (!iwait) begin
               fill_we    = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         miss_word <= '0;
         valid     <= '0;
      end else begin
         if (miss_take) begin
            miss_word <= imemaddr[31:2];
         end
         if (fill_we) begin
            valid[fill_idx] <= 1'b1;
         end
      end
   end

   // NOTE: tag/data arrays are not reset; the valid bit alone qualifies
   // them, which keeps the arrays mappable onto plain memory. Reset still
   // blocks the write so an abandoned fill leaves the frame untouched.
   always_ff @(posedge CLK) begin
      if (fill_we && !RST) begin
         tags[fill_idx] <= fill_tag;
         data[fill_idx] <= iload;
      end
   end

endmodule

// File: tb/tb_icache.sv
// tb_icache -- directed checks of the listed fetch scenarios followed by a
// randomized run scored against a behavioural direct-mapped cache model.
module tb_icache;
   import cpu_types_pkg::*;

   localparam int SETS = 16;

   logic  CLK = 1'b0;
   logic  RST;
   logic  imemREN;
   word_t imemaddr;
   logic  ihit;
   word_t imemload;
   logic  iREN;
   word_t iaddr;
   logic  iwait;
   word_t iload;

   int vectors     = 0;
   int miscompares = 0;

   icache #(.SETS(SETS), .IDX_W(4)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .imemREN  (imemREN),
      .imemaddr (imemaddr),
      .ihit     (ihit),
      .imemload (imemload),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iwait    (iwait),
      .iload    (iload)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input word_t act, input word_t exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory contents seen by the random phase.
   function automatic word_t memf(input word_t a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   // ---------------- scoreboard ----------------
   typedef struct {
      bit    is_fill;
      word_t val;
   } ev_t;

   ev_t sb[$];
   bit  mon_en = 1'b0;

   always @(negedge CLK) begin
      if (mon_en) begin
         if (iREN && !iwait) begin
            if (sb.size() == 0) begin
               check("sb_unexpected_fill", iaddr, 32'hFFFF_FFFF);
            end else begin
               check("sb_kind_fill", 32'(sb[0].is_fill), 32'd1);
               check("sb_fill_addr", iaddr, sb[0].val);
               void'(sb.pop_front());
            end
         end
         if (ihit) begin
            if (sb.size() == 0) begin
               check("sb_unexpected_hit", imemload, 32'hFFFF_FFFF);
            end else begin
               check("sb_kind_hit", 32'(sb[0].is_fill), 32'd0);
               check("sb_hit_data", imemload, sb[0].val);
               void'(sb.pop_front());
            end
         end
      end
   end

   // ---------------- reference model ----------------
   bit    m_valid [SETS];
   word_t m_word  [SETS];   // word address cached in each frame

   // ---------------- helpers ----------------
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Miss on a, memory stalls 'waits' cycles then returns d; the re-lookup hits.
   task automatic fill(input word_t a, input word_t d, input int waits, input string nm);
      imemREN  = 1'b1;
      imemaddr = a;
      iwait    = (waits > 0);
      iload    = d;
      @(negedge CLK);
      check({nm, "_miss"}, 32'(ihit), 32'd0);
      for (int k = 0; k <= waits; k++) begin
         step();
         iwait = (k < waits);
         @(negedge CLK);
         check({nm, "_iREN"}, 32'(iREN), 32'd1);
         check({nm, "_iaddr"}, iaddr, a & ~32'h3);
         check({nm, "_nohit_fill"}, 32'(ihit), 32'd0);
      end
      step();
      iwait = 1'b1;
      @(negedge CLK);
      check({nm, "_rehit"}, 32'(ihit), 32'd1);
      check({nm, "_data"}, imemload, d);
      check({nm, "_idle_iREN"}, 32'(iREN), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      word_t a;
      int    idx;
      bit    got;

      RST      = 1'b1;
      imemREN  = 1'b0;
      imemaddr = '0;
      iwait    = 1'b1;
      iload    = '0;

      // Reset state
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("rst_ihit", 32'(ihit), 32'd0);
      check("rst_imemload", imemload, 32'd0);
      check("rst_iREN", 32'(iREN), 32'd0);
      check("rst_iaddr", iaddr, 32'd0);
      step();
      RST = 1'b0;
      @(negedge CLK);
      check("post_rst_iREN", 32'(iREN), 32'd0);
      check("post_rst_iaddr", iaddr, 32'd0);

      // First fill: three stall cycles
      step();
      fill(32'h0000_0000, 32'h3C01_0001, 3, "fill0");

      // Byte offset ignored on hit
      step();
      imemaddr = 32'h0000_0002;
      @(negedge CLK);
      check("offset_hit", 32'(ihit), 32'd1);
      check("offset_data", imemload, 32'h3C01_0001);

      // Conflict in index 1
      step();
      fill(32'h0000_0004, 32'hAAAA_0000, 0, "fill4");
      step();
      fill(32'h0000_0044, 32'hBBBB_0000, 2, "fill44");
      step();
      fill(32'h0000_0004, 32'hAAAA_0000, 1, "refill4");

      // Fill not redirected by address change / REN drop
      step();
      imemREN  = 1'b1;
      imemaddr = 32'h0000_0010;
      iwait    = 1'b1;
      iload    = 32'hCCCC_0010;
      @(negedge CLK);
      check("redir_miss", 32'(ihit), 32'd0);
      step();
      imemaddr = 32'h0000_0020;
      imemREN  = 1'b0;
      @(negedge CLK);
      check("redir_iREN", 32'(iREN), 32'd1);
      check("redir_iaddr_hold", iaddr, 32'h0000_0010);
      step();
      iwait = 1'b0;
      @(negedge CLK);
      check("redir_iaddr_done", iaddr, 32'h0000_0010);
      step();
      iwait    = 1'b1;
      imemREN  = 1'b1;
      imemaddr = 32'h0000_0010;
      @(negedge CLK);
      check("redir_later_hit", 32'(ihit), 32'd1);
      check("redir_later_data", imemload, 32'hCCCC_0010);

      // Reset mid-fill
      step();
      imemaddr = 32'h0000_0008;
      iload    = 32'h8888_0008;
      @(negedge CLK);
      check("abort_miss", 32'(ihit), 32'd0);
      step();
      @(negedge CLK);
      check("abort_fill_iREN", 32'(iREN), 32'd1);
      RST = 1'b1;
      step();
      RST = 1'b0;
      @(negedge CLK);
      check("abort_iREN_drop", 32'(iREN), 32'd0);
      check("abort_iaddr", iaddr, 32'd0);
      check("abort_remiss", 32'(ihit), 32'd0);
      step();
      iwait = 1'b0;
      @(negedge CLK);
      check("abort_refill_iaddr", iaddr, 32'h0000_0008);
      step();
      iwait = 1'b1;
      @(negedge CLK);
      check("abort_refill_hit", 32'(ihit), 32'd1);
      check("abort_refill_data", imemload, 32'h8888_0008);

      // No request -> no hit even with a matching frame
      step();
      imemREN = 1'b0;
      @(negedge CLK);
      check("noreq_ihit", 32'(ihit), 32'd0);
      check("noreq_imemload", imemload, 32'd0);
      check("noreq_iREN", 32'(iREN), 32'd0);
      check("noreq_iaddr", iaddr, 32'd0);

      // Reset clears every frame: earlier fill of 0x0 now misses
      step();
      imemREN  = 1'b1;
      imemaddr = 32'h0000_0000;
      @(negedge CLK);
      check("rst_cleared_miss", 32'(ihit), 32'd0);
      RST = 1'b0;

      // ---------------- randomized phase ----------------
      step();
      RST     = 1'b1;
      imemREN = 1'b0;
      step();
      RST = 1'b0;
      for (int i = 0; i < SETS; i++) begin
         m_valid[i] = 1'b0;
         m_word[i]  = '0;
      end
      mon_en = 1'b1;

      for (int n = 0; n < 300; n++) begin
         step();
         iwait = 1'($urandom_range(0, 1));
         iload = memf(iaddr);
         if ($urandom_range(0, 3) == 0) begin
            imemREN  = 1'b0;
            imemaddr = $urandom;
            continue;
         end
         a   = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
         idx = int'((a >> 2) % SETS);
         if (!(m_valid[idx] && m_word[idx] == (a >> 2))) begin
            sb.push_back('{is_fill: 1'b1, val: a & ~32'h3});
            m_valid[idx] = 1'b1;
            m_word[idx]  = a >> 2;
         end
         sb.push_back('{is_fill: 1'b0, val: memf(a & ~32'h3)});
         imemREN  = 1'b1;
         imemaddr = a;
         got      = 1'b0;
         for (int c = 0; c < 60; c++) begin
            @(negedge CLK);
            if (ihit) begin
               got = 1'b1;
               break;
            end
            step();
            iwait = 1'($urandom_range(0, 1));
            iload = memf(iaddr);
         end
         if (!got) begin
            check("rand_hit_timeout", 32'd0, 32'd1);
            sb.delete();
         end
      end

      step();
      imemREN = 1'b0;
      repeat (3) @(negedge CLK);
      mon_en = 1'b0;
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter SETS, default 16, meaning number of direct-mapped frames (power of two, min 2).
REQ-002 SHALL have parameter IDX_W, default 4, meaning log2(SETS); tag width = 30-IDX_W.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port imemREN  input  1  datapath instruction read request.
REQ-006 SHALL have port imemaddr  input  32  datapath fetch address; bits [1:0] ignored.
REQ-007 SHALL have port ihit  output  1  requested word valid this cycle.
REQ-008 SHALL have port imemload  output  32  instruction word; 32'h0 when ihit=0.
REQ-009 SHALL have port iREN  output  1  fill request to memory controller.
REQ-010 SHALL have port iaddr  output  32  fill address, word-aligned.
REQ-011 SHALL have port iwait  input  1  memory busy; iload valid in any cycle with iREN=1 and iwait=0.
REQ-012 SHALL have port iload  input  32  fill data from memory controller.

Function
REQ-013 SHALL decode address as tag=[31:IDX_W+2], idx=[IDX_W+1:2], byte offset=[1:0].
REQ-014 SHALL hold per frame: valid bit, tag, 32-bit data word.
REQ-015 SHALL implement FSM with states IDLE and FILL only.
REQ-016 IDLE: ihit = imemREN & valid[idx] & (tag[idx]==tag); imemload = data[idx] when ihit; combinational, zero-cycle hit latency.
REQ-017 IDLE, imemREN=1 and lookup miss: latch word-aligned imemaddr into miss register, go to FILL next cycle; ihit=0.
REQ-018 IDLE, imemREN=0: no state change, ihit=0, iREN=0.
REQ-019 FILL: iREN=1, iaddr=miss register, ihit=0 regardless of lookup.
REQ-020 FILL with iwait=0: write iload, latched tag, valid=1 into frame at latched idx (overwrite any occupant); return to IDLE next cycle.
REQ-021 FILL with iwait=1: remain in FILL, iREN and iaddr held stable.
REQ-022 Miss penalty SHALL be memory latency + 1 cycle; the re-lookup in IDLE after fill hits if address unchanged.
REQ-023 Changes of imemaddr or deassertion of imemREN during FILL SHALL NOT abort or redirect the fill; the latched address completes.
REQ-024 In IDLE, iREN=0 and iaddr=32'h0.
REQ-025 Frames SHALL never be invalidated except by reset; no write path from datapath.

Reset
REQ-026 RST=1 at a clock edge SHALL clear all valid bits, force state IDLE, clear miss register; tag/data contents don't-care.
REQ-027 During and after reset until first miss: ihit=0, imemload=0, iREN=0, iaddr=0.
REQ-028 RST asserted mid-FILL SHALL abandon the fill; the frame is not written and iREN drops on the following cycle.

Structure
REQ-029 Shared package cpu_types_pkg SHALL hold word_t, ITAG_W/IIDX_W constants, icachef_t packed struct (tag, idx, bytoff), and icache_frame_t (valid, tag, data).
REQ-030 FSM state enum SHALL be local to icache.
REQ-031 No sub-module; frame array is a register array inside icache.

Verification
REQ-032 Reset, imemREN=1, imemaddr=0x00000000, iwait=1 for 3 cycles then 0 with iload=0x3C010001 -> iREN=1/iaddr=0 for 4 cycles, then ihit=1, imemload=0x3C010001 in IDLE.
REQ-033 After REQ-032 fill, imemaddr=0x00000002 -> ihit=1, imemload=0x3C010001 same cycle (offset ignored).
REQ-034 Fill 0x00000004 (data 0xAAAA0000), then 0x00000044 (same idx 1, data 0xBBBB0000), then 0x00000004 -> miss again, iREN=1, iaddr=0x00000004.
REQ-035 Miss on 0x00000010, in FILL change imemaddr to 0x00000020 and drop imemREN -> iaddr stays 0x00000010; frame 4 written; later 0x00000010 hits.
REQ-036 Miss on 0x00000008, RST pulsed while iwait=1 -> iREN=0 next cycle; request 0x00000008 again -> miss (frame not valid).
REQ-037 imemREN=0 with valid matching frame -> ihit=0, imemload=0, iREN=0.
